// File: rtl/pdm_dac.sv
// rtl/pdm_dac.sv - PCM-to-PDM transmitter with two-entry holding path and first-order modulator
// Optional LFSR dither carry-in enabled by defining PDM_DAC_DITHER_EN.
module pdm_dac #(
  parameter int SAMPLE_DEPTH = 16,
  parameter int CLK_DIV      = 4,
  parameter int OSR          = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_DEPTH-1:0] in_sample,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    pdm_clk,
  output logic                    pdm_out,
  output logic                    underrun
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (OSR > 2) ? $clog2(OSR) : 1;
  localparam int N     = SAMPLE_DEPTH;

  logic [DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_pdm_clk;
  logic             r_pdm_out;
  logic             r_in_ready;
  logic             r_underrun;
  logic [N-1:0]     r_acc;
  logic [N-1:0]     r_cur;
  logic [N-1:0]     r_next;
  logic             r_next_full;

  logic [DIV_W-1:0] w_div_nxt;
  logic             w_strobe;
  logic             w_boundary;
  logic             w_xfer;
  logic             w_next_full_nxt;
  logic [N-1:0]     w_sel;
  logic [N-1:0]     w_u;
  logic [N:0]       w_sum;
  logic             w_cin;

  always_comb begin
    w_strobe   = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    w_div_nxt  = w_strobe ? '0 : r_div_cnt + 1'b1;
    w_boundary = w_strobe && (r_bit_cnt == '0);
    w_xfer     = in_valid && r_in_ready;

    // A boundary only ever drains a sample that was already registered.
    w_next_full_nxt = r_next_full;
    if (w_boundary && r_next_full) begin
      w_next_full_nxt = 1'b0;
    end else if (w_xfer) begin
      w_next_full_nxt = 1'b1;
    end

    w_sel = r_cur;
    if (w_boundary) begin
      w_sel = r_next_full ? r_next : '0;
    end

    w_u   = w_sel ^ {1'b1, {(N-1){1'b0}}};
    w_sum = {1'b0, r_acc} + {1'b0, w_u} + {{N{1'b0}}, w_cin};
  end

`ifdef PDM_DAC_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cin     = r_lfsr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else if (w_strobe) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end
`else
  assign w_cin = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_pdm_clk <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_pdm_clk <= (w_div_nxt >= DIV_W'(CLK_DIV / 2));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_next      <= '0;
      r_next_full <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      if (w_xfer) begin
        r_next <= in_sample;
      end
      r_next_full <= w_next_full_nxt;
      r_in_ready  <= !w_next_full_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_cur      <= '0;
      r_acc      <= '0;
      r_pdm_out  <= 1'b0;
      r_underrun <= 1'b0;
    end else if (w_strobe) begin
      r_bit_cnt <= (r_bit_cnt == BIT_W'(OSR - 1)) ? '0 : r_bit_cnt + 1'b1;
      r_cur     <= w_sel;
      r_acc     <= w_sum[N-1:0];
      r_pdm_out <= w_sum[N];
      if (w_boundary && !r_next_full) begin
        r_underrun <= 1'b1;
      end
    end
  end

  assign in_ready = r_in_ready;
  assign pdm_clk  = r_pdm_clk;
  assign pdm_out  = r_pdm_out;
  assign underrun = r_underrun;

endmodule

// File: doc/pdm_dac.md
# pdm_dac

PCM-to-PDM transmitter: accepts signed PCM samples over a valid/ready handshake and drives a 1-bit pulse-density stream plus bit clock for a PDM amplifier or speaker. It sits on the audio output path, producing the same line format (PDM bit stream plus divided bit clock) that our PDM microphone input path decodes. It uses a two-entry sample holding path, a first-order error-feedback modulator, a zero-order hold of OSR bits per sample, and a sticky underrun flag.

## Interface
- SAMPLE_DEPTH, 16, PCM sample width N (two's complement)
- CLK_DIV, 4, clk cycles per PDM bit; even, ≥2
- OSR, 64, PDM bits per PCM sample; ≥2
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- in_sample  in  SAMPLE_DEPTH  signed PCM sample
- in_valid  in  1  in_sample valid
- in_ready  out  1  high when the `next` register is empty
- pdm_clk  out  1  PDM bit clock, clk/CLK_DIV, 50% duty
- pdm_out  out  1  PDM data; changes only when pdm_clk falls
- underrun  out  1  sticky; set when a sample boundary finds no sample queued

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pdm_clk is registered: low for div_cnt < CLK_DIV/2, high otherwise. Strobe = the cycle div_cnt wraps CLK_DIV-1→0, which is also the pdm_clk falling edge.
- Bit counter: bit_cnt counts 0..OSR-1 and advances on each strobe. A strobe with bit_cnt==0 is a sample boundary.
- Holding path: registers `next` and `next_full`, and register `cur`.
  - in_ready = !next_full, registered.
  - Transfer when in_valid && in_ready: next←in_sample and next_full←1.
- At a sample boundary:
  - If next_full: cur←next and next_full←0.
  - Otherwise: cur←0 (mute) and underrun←1.
  - The modulator step on that same strobe uses the newly selected value.
- Modulator (on each strobe):
  - u = cur XOR 2^(N-1), giving offset binary in N bits, unsigned.
  - {c, acc} = acc + u (+ dither bit), with acc N bits; pdm_out←c.
  - Ones density = u/2^N: 0 maps to 50%, −2^(N-1) to 0%, 2^(N-1)−1 to (2^N−1)/2^N.
- Simultaneous events:
  - A transfer in the same cycle as a boundary is not visible to that boundary. The boundary sees the registered next_full=0, so underrun is set and the new sample waits for the following boundary.
  - A boundary draining `next` and a transfer cannot coincide, because in_ready was 0.
- underrun clears only on rst.

## Timing
- Reset values: pdm_clk 0, pdm_out 0, in_ready 1, underrun 0. Internal reset values: div_cnt 0, bit_cnt 0, acc 0, cur 0, next_full 0.
- First strobe occurs CLK_DIV cycles after rst deasserts. It is a boundary, so a sample must be accepted at least one cycle earlier to avoid underrun.
- in_ready returns to 1 on the clk edge following the boundary that drained `next`.
- pdm_out is registered at the strobe. It is stable for CLK_DIV cycles, including across the pdm_clk rising edge at div_cnt=CLK_DIV/2.
- Latency from accepted sample to first output bit: until the next boundary, at most OSR·CLK_DIV+1 cycles.
- rst mid-operation: all state returns to reset values immediately. The queued sample is discarded; no partial bit or clock glitch beyond the asynchronous drop.

## Configuration
- PDM_DAC_DITHER_EN defined:
  - Adds a 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 0xACE1, reloaded on rst.
  - The LFSR advances on each strobe.
  - Its bit 0 (value before advance) is added as carry-in to the accumulator sum.
- Undefined: carry-in is 0 and no LFSR is present. Output is fully deterministic as specified above.

## Test plan
- CLK_DIV=4, OSR=4, dither off; feed 0x0000 continuously → pdm_out bits 0,1,0,1 repeating; pdm_clk period 4 clk; underrun stays 0.
- Feed 0x8000 (−32768) continuously → pdm_out constant 0. Feed 0x7FFF → 65535 ones in every 65536 bits.
- Feed 0x4000 → u=0xC000, bit pattern 1,1,0,1 repeating (75% density).
- Hold in_valid=0 after one sample → at the second boundary underrun=1, and output drops to 50% density (mute); underrun stays 1 until rst.
- Assert in_valid exactly on a boundary cycle with next empty → underrun=1, and the sample appears at the next boundary; in_ready is low for exactly one sample period.
- Assert rst mid-sample → pdm_out=0, pdm_clk=0, in_ready=1, underrun=0 the same cycle. With PDM_DAC_DITHER_EN, an identical stimulus after rst reproduces the bit-identical pdm_out sequence.
